// File: rtl/qsfp_cage_sequencer.sv
// qsfp_cage_sequencer: per-cage QSFP presence debounce and ResetL bring-up sequencing.
// Each cage independently runs ABSENT -> RESET_ASSERT -> INIT_WAIT -> READY.
module qsfp_cage_sequencer #(
  parameter int C_NUM_CAGES        = 2,
  parameter int RESET_PULSE_CYCLES = 1000,
  parameter int INIT_WAIT_CYCLES   = 200_000_000,
  parameter int DEBOUNCE_CYCLES    = 1_000_000
) (
  input  logic                     gty_sysclk_i,
  input  logic                     gty_rst_n_i,
  input  logic [C_NUM_CAGES-1:0]   qsfp_modprs_n_i,
  input  logic [C_NUM_CAGES-1:0]   qsfp_int_n_i,
  input  logic [C_NUM_CAGES-1:0]   reset_req_i,
  output logic [C_NUM_CAGES-1:0]   qsfp_reset_n_o,
  output logic [C_NUM_CAGES-1:0]   present_o,
  output logic [C_NUM_CAGES-1:0]   ready_o,
  output logic [C_NUM_CAGES-1:0]   int_o,
  output logic [8*C_NUM_CAGES-1:0] reset_count_o
);

  localparam int CNT_MAX = (RESET_PULSE_CYCLES > INIT_WAIT_CYCLES) ? RESET_PULSE_CYCLES : INIT_WAIT_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int DEB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(RESET_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] INIT_LAST  = CNT_W'(INIT_WAIT_CYCLES - 1);
  localparam logic [DEB_W-1:0] DEB_LAST   = DEB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_ABSENT       = 2'd0,
    ST_RESET_ASSERT = 2'd1,
    ST_INIT_WAIT    = 2'd2,
    ST_READY        = 2'd3
  } state_t;

  for (genvar g = 0; g < C_NUM_CAGES; g++) begin : g_cage
    logic [1:0]       prs_sync_r;
    logic [1:0]       int_sync_r;
    logic             present_r;
    logic [DEB_W-1:0] deb_cnt_r;
    state_t           state_r;
    state_t           state_s;
    logic [CNT_W-1:0] cyc_cnt_r;
    logic [CNT_W-1:0] cyc_cnt_s;
    logic [7:0]       rst_cnt_r;
    logic             reset_n_s;
    logic             ready_s;
    logic             enter_s;

    // Two-stage synchronisers, preset to "absent, no interrupt"
    always_ff @(posedge gty_sysclk_i or negedge gty_rst_n_i) begin
      if (!gty_rst_n_i) begin
        prs_sync_r <= 2'b11;
        int_sync_r <= 2'b11;
      end else begin
        prs_sync_r <= {prs_sync_r[0], qsfp_modprs_n_i[g]};
        int_sync_r <= {int_sync_r[0], qsfp_int_n_i[g]};
      end
    end

    // Presence debounce: count consecutive synced samples disagreeing with present_r
    always_ff @(posedge gty_sysclk_i or negedge gty_rst_n_i) begin
      if (!gty_rst_n_i) begin
        present_r <= 1'b0;
        deb_cnt_r <= '0;
      end else if ((~prs_sync_r[1]) != present_r) begin
        if (deb_cnt_r == DEB_LAST) begin
          present_r <= ~present_r;
          deb_cnt_r <= '0;
        end else begin
          deb_cnt_r <= deb_cnt_r + DEB_W'(1);
        end
      end else begin
        deb_cnt_r <= '0;
      end
    end

    // Sequencer state, phase counter and saturating reset-pulse count
    always_ff @(posedge gty_sysclk_i or negedge gty_rst_n_i) begin
      if (!gty_rst_n_i) begin
        state_r   <= ST_ABSENT;
        cyc_cnt_r <= '0;
        rst_cnt_r <= 8'd0;
      end else begin
        state_r   <= state_s;
        cyc_cnt_r <= cyc_cnt_s;
        if (enter_s && (rst_cnt_r != 8'hFF)) begin
          rst_cnt_r <= rst_cnt_r + 8'd1;
        end
      end
    end

    // Output decode and next state; loss of presence overrides requests and expiry
    always_comb begin
      state_s   = state_r;
      cyc_cnt_s = cyc_cnt_r;
      reset_n_s = 1'b0;
      ready_s   = 1'b0;
      case (state_r)
        ST_INIT_WAIT: begin
          reset_n_s = 1'b1;
          ready_s   = 1'b0;
        end
        ST_READY: begin
          reset_n_s = 1'b1;
          ready_s   = 1'b1;
        end
        default: begin
          reset_n_s = 1'b0;
          ready_s   = 1'b0;
        end
      endcase
      if (!present_r) begin
        state_s   = ST_ABSENT;
        cyc_cnt_s = '0;
      end else begin
        case (state_r)
          ST_ABSENT: begin
            state_s   = ST_RESET_ASSERT;
            cyc_cnt_s = '0;
          end
          ST_RESET_ASSERT: begin
            if (cyc_cnt_r == PULSE_LAST) begin
              state_s   = ST_INIT_WAIT;
              cyc_cnt_s = '0;
            end else begin
              cyc_cnt_s = cyc_cnt_r + CNT_W'(1);
            end
          end
          ST_INIT_WAIT: begin
            if (reset_req_i[g]) begin
              state_s   = ST_RESET_ASSERT;
              cyc_cnt_s = '0;
            end else if (cyc_cnt_r == INIT_LAST) begin
              state_s   = ST_READY;
              cyc_cnt_s = '0;
            end else begin
              cyc_cnt_s = cyc_cnt_r + CNT_W'(1);
            end
          end
          ST_READY: begin
            if (reset_req_i[g]) begin
              state_s   = ST_RESET_ASSERT;
              cyc_cnt_s = '0;
            end else begin
              state_s   = ST_READY;
            end
          end
          default: begin
            state_s   = ST_ABSENT;
            cyc_cnt_s = '0;
          end
        endcase
      end
    end

    assign enter_s = (state_s == ST_RESET_ASSERT) && (state_r != ST_RESET_ASSERT);

    assign qsfp_reset_n_o[g]       = reset_n_s;
    assign present_o[g]            = present_r;
    assign ready_o[g]              = ready_s;
    assign int_o[g]                = ready_s & ~int_sync_r[1];
    assign reset_count_o[8*g +: 8] = rst_cnt_r;
  end

endmodule

// File: tb/tb_qsfp_cage_sequencer.sv
// Bench for qsfp_cage_sequencer: timestamp-based reference model feeding a per-cycle scoreboard,
// directed insertion milestones, then randomized presence/interrupt/request/reset traffic.
module tb_qsfp_cage_sequencer;
  localparam int NC = 2;
  localparam int P  = 4;
  localparam int I  = 8;
  localparam int D  = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NC-1:0]   modprs_n;
  logic [NC-1:0]   int_n;
  logic [NC-1:0]   reset_req;
  logic [NC-1:0]   qsfp_reset_n;
  logic [NC-1:0]   present;
  logic [NC-1:0]   ready;
  logic [NC-1:0]   int_out;
  logic [8*NC-1:0] reset_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  qsfp_cage_sequencer #(
    .C_NUM_CAGES(NC), .RESET_PULSE_CYCLES(P), .INIT_WAIT_CYCLES(I), .DEBOUNCE_CYCLES(D)
  ) dut (
    .gty_sysclk_i(clk), .gty_rst_n_i(rst_n),
    .qsfp_modprs_n_i(modprs_n), .qsfp_int_n_i(int_n), .reset_req_i(reset_req),
    .qsfp_reset_n_o(qsfp_reset_n), .present_o(present), .ready_o(ready),
    .int_o(int_out), .reset_count_o(reset_count)
  );

  // Reference model: presence debounce from delayed raw samples, sequencing from RESET_ASSERT entry timestamps
  int            edge_n;
  logic [NC-1:0] prs_hist[$];
  logic [NC-1:0] int_hist[$];
  bit            m_present[NC];
  bit            m_absent[NC];
  int            m_streak[NC];
  int            m_entry[NC];
  int            m_cnt[NC];
  logic [23:0]   exp_q[$];

  typedef struct {
    int         e;
    logic [3:0] v;    // {present0, reset_n0, ready0, ready1}
    logic [7:0] cnt;  // cage 0 count
  } dir_t;
  dir_t dir_q[$];

  task automatic model_reset();
    edge_n = 0;
    prs_hist.delete();
    int_hist.delete();
    prs_hist.push_back('1);
    prs_hist.push_back('1);
    int_hist.push_back('1);
    for (int c = 0; c < NC; c++) begin
      m_present[c] = 1'b0;
      m_absent[c]  = 1'b1;
      m_streak[c]  = 0;
      m_entry[c]   = 0;
      m_cnt[c]     = 0;
    end
  endtask

  always @(negedge rst_n) begin
    model_reset();
    if (exp_q.size() > 0) exp_q[exp_q.size()-1] = 24'h0;
  end

  always @(posedge clk) begin
    logic [NC-1:0] s_prs;
    logic [NC-1:0] s_int;
    logic [23:0]   e;
    int            age;
    if (!rst_n) begin
      model_reset();
      exp_q.push_back(24'h0);
    end else begin
      edge_n++;
      prs_hist.push_back(modprs_n);
      int_hist.push_back(int_n);
      s_prs = prs_hist.pop_front();
      s_int = int_hist.pop_front();
      e = 24'h0;
      for (int c = 0; c < NC; c++) begin
        age = (edge_n - 1) - m_entry[c];
        if (!m_present[c]) begin
          m_absent[c] = 1'b1;
        end else if (m_absent[c]) begin
          m_absent[c] = 1'b0;
          m_entry[c]  = edge_n;
          if (m_cnt[c] < 255) m_cnt[c]++;
        end else if (reset_req[c] && age >= P) begin
          m_entry[c] = edge_n;
          if (m_cnt[c] < 255) m_cnt[c]++;
        end
        if ((!s_prs[c]) != m_present[c]) begin
          m_streak[c]++;
          if (m_streak[c] == D) begin
            m_present[c] = !m_present[c];
            m_streak[c]  = 0;
          end
        end else begin
          m_streak[c] = 0;
        end
        age = edge_n - m_entry[c];
        e[c]      = !m_absent[c] && (age >= P);
        e[2+c]    = m_present[c];
        e[4+c]    = !m_absent[c] && (age >= P + I);
        e[6+c]    = e[4+c] && !s_int[c];
        e[8+8*c +: 8] = 8'(m_cnt[c]);
      end
      exp_q.push_back(e);
    end
  end

  // Monitor: one scoreboard comparison per cycle plus any directed milestone due at this edge
  always @(negedge clk) begin
    logic [23:0] act;
    logic [23:0] exp;
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      act = {reset_count, int_out, ready, present, qsfp_reset_n};
      n_tests++;
      if (act !== exp) begin
        n_fail++;
        $display("FAIL outputs t=%0t edge=%0d actual=%h required=%h", $time, edge_n, act, exp);
      end
    end
    while (dir_q.size() > 0 && dir_q[0].e == edge_n && rst_n) begin
      dir_t d;
      d = dir_q.pop_front();
      n_tests++;
      if ({present[0], qsfp_reset_n[0], ready[0], ready[1]} !== d.v || reset_count[7:0] !== d.cnt) begin
        n_fail++;
        $display("FAIL insertion_edge%0d actual={p,rn,rdy,rdyB}=%b cnt=%0d required=%b cnt=%0d",
                 d.e, {present[0], qsfp_reset_n[0], ready[0], ready[1]}, reset_count[7:0], d.v, d.cnt);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_req(input int c);
    reset_req[c] = 1'b1;
    @(negedge clk);
    reset_req = '0;
  endtask

  task automatic add_dir(input int e, input logic [3:0] v, input logic [7:0] cnt);
    dir_t d;
    d.e = e; d.v = v; d.cnt = cnt;
    dir_q.push_back(d);
  endtask

  int hold[NC];

  initial begin
    rst_n = 1'b0; modprs_n = '1; int_n = '1; reset_req = '0;
    tick(3);
    add_dir(4,  4'b0000, 8'd0);
    add_dir(5,  4'b1000, 8'd0);
    add_dir(6,  4'b1000, 8'd1);
    add_dir(9,  4'b1000, 8'd1);
    add_dir(10, 4'b1100, 8'd1);
    add_dir(17, 4'b1100, 8'd1);
    add_dir(18, 4'b1110, 8'd1);
    rst_n = 1'b1;
    modprs_n[0] = 1'b0;
    tick(25);
    // glitch shorter than the debounce window
    modprs_n[0] = 1'b1; tick(2); modprs_n[0] = 1'b0; tick(10);
    // request in READY, second request during RESET_ASSERT
    pulse_req(0); tick(1); pulse_req(0); tick(20);
    // removal during INIT_WAIT, then reinsertion
    pulse_req(0); tick(6);
    modprs_n[0] = 1'b1; tick(10);
    modprs_n[0] = 1'b0; tick(25);
    // saturate the reset counter
    for (int k = 0; k < 300; k++) begin
      pulse_req(0); tick(4);
    end
    tick(20);
    // request coincident with the edge that first sees debounced removal
    modprs_n[0] = 1'b1; tick(5); pulse_req(0); tick(5);
    modprs_n[0] = 1'b0; tick(25);
    // cage B into INIT_WAIT while cage A is READY, then interrupts on both
    modprs_n[1] = 1'b0; tick(12);
    int_n = 2'b00; tick(4);
    @(posedge clk); #1 rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1; int_n = '1; tick(30);
    // randomized traffic
    for (int c = 0; c < NC; c++) hold[c] = $urandom_range(1, 40);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int c = 0; c < NC; c++) begin
        if (hold[c] == 0) begin
          modprs_n[c] = ~modprs_n[c];
          hold[c] = $urandom_range(1, 40);
        end else begin
          hold[c]--;
        end
        reset_req[c] = ($urandom_range(0, 5) == 0);
      end
      if ($urandom_range(0, 7) == 0) int_n = 2'($urandom);
      if ($urandom_range(0, 599) == 0) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    reset_req = '0;
    tick(5);
    if (dir_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL directed_pending actual=%0d required=0", dir_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/qsfp_cage_sequencer.md
# qsfp_cage_sequencer

Per-cage QSFP module bring-up sequencer for the dual-QSFP GTY test designs. It sits directly upstream of the GTY/IBERT top level and drives the QSFP reset lines that the top level currently ties inactive. It also debounces module presence and produces a per-cage `ready` that software and downstream link logic use to gate transceiver use. Each cage runs an independent present → reset pulse → init wait → ready sequence.

## Interface
Parameters:
- `C_NUM_CAGES`, 2: number of QSFP cages (index 0 = cage A, 1 = cage B).
- `RESET_PULSE_CYCLES`, 1000: ResetL low time in clocks (≥10 µs at 100 MHz).
- `INIT_WAIT_CYCLES`, 200_000_000: post-reset module init time in clocks (2 s at 100 MHz).
- `DEBOUNCE_CYCLES`, 1_000_000: consecutive stable synced samples needed to change the presence state.

Ports:
- `gty_sysclk_i` in 1: free-running system clock; all logic in this domain.
- `gty_rst_n_i` in 1: asynchronous active-low reset.
- `qsfp_modprs_n_i` in C_NUM_CAGES: ModPrsL from each cage, asynchronous, low = present.
- `qsfp_int_n_i` in C_NUM_CAGES: IntL from each cage, asynchronous, low = interrupt.
- `reset_req_i` in C_NUM_CAGES: single-cycle software request to re-run reset for that cage.
- `qsfp_reset_n_o` out C_NUM_CAGES: ResetL to each cage (bit0 → QSFP_RESET_A, bit1 → QSFP_RESET_B).
- `present_o` out C_NUM_CAGES: debounced presence.
- `ready_o` out C_NUM_CAGES: module out of reset and init time elapsed.
- `int_o` out C_NUM_CAGES: synced interrupt, qualified by ready.
- `reset_count_o` out 8×C_NUM_CAGES: per-cage saturating count of reset pulses issued; cage i occupies bits [8i+7:8i].

## Operation
- Each ModPrsL and IntL bit passes through a 2-FF synchroniser before any use.
- Presence debounce, per cage:
  - The counter tracks consecutive synced samples that differ from `present_o`. It clears when a sample equals `present_o`.
  - When the counter reaches DEBOUNCE_CYCLES, `present_o` toggles and the counter clears.
- Per-cage FSM states:
  - ABSENT: `reset_n` = 0, `ready` = 0. Goes to RESET_ASSERT when `present_o` = 1.
  - RESET_ASSERT: `reset_n` = 0. Stays exactly RESET_PULSE_CYCLES cycles, then goes to INIT_WAIT.
  - INIT_WAIT: `reset_n` = 1, `ready` = 0. Stays exactly INIT_WAIT_CYCLES cycles, then goes to READY.
  - READY: `reset_n` = 1, `ready` = 1.
- From INIT_WAIT or READY, `reset_req_i` goes to RESET_ASSERT with the cycle counter reloaded.
- `reset_req_i` is ignored in ABSENT and in RESET_ASSERT; the pulse is not extended.
- From any state, `present_o` = 0 goes to ABSENT on the next edge. This has priority over `reset_req_i` and over counter expiry.
- `reset_count_o` increments on every entry to RESET_ASSERT and saturates at 255.
- `int_o` = `ready_o` AND NOT (synced IntL).
- Cycle counters are sized by $clog2 of the larger of RESET_PULSE_CYCLES and INIT_WAIT_CYCLES.
- Cages share no state.

## Timing
- Values while `gty_rst_n_i` is low, per cage:
  - `qsfp_reset_n_o` = 0, `present_o` = 0, `ready_o` = 0, `int_o` = 0, `reset_count_o` = 0.
  - Synchronisers preset to 1 (absent, no interrupt).
  - FSM = ABSENT.
- Outputs decode directly from registered state. There is no extra output stage.
- Insertion latency, with ModPrsL low and stable before edge 1:
  - `present_o` rises after edge 2+DEBOUNCE_CYCLES.
  - `qsfp_reset_n_o` stays 0 through RESET_ASSERT. RESET_ASSERT is entered one edge after `present_o` rises.
  - `qsfp_reset_n_o` rises RESET_PULSE_CYCLES edges after RESET_ASSERT entry.
  - `ready_o` rises INIT_WAIT_CYCLES edges after `qsfp_reset_n_o` rises.
- Removal latency: `present_o` falls 2+DEBOUNCE_CYCLES edges after ModPrsL goes high. `ready_o` and `qsfp_reset_n_o` fall one edge later.
- `reset_req_i` latency: seen at edge n, `qsfp_reset_n_o` and `ready_o` are 0 after edge n.
- Glitch shorter than DEBOUNCE_CYCLES: no change to `present_o`.
- Reset asserted mid-sequence: all outputs go to reset values immediately. The sequence restarts from ABSENT after release.
- `int_o` lags IntL by 2 edges.

## Test plan
Parameters for all scenarios: RESET_PULSE_CYCLES=4, INIT_WAIT_CYCLES=8, DEBOUNCE_CYCLES=3.

1. Insertion: release reset, drive cage A ModPrsL low → `present_o[0]` at edge 5, `qsfp_reset_n_o[0]` low for edges 6–9 then high, `ready_o[0]` at edge 18, `reset_count_o[7:0]` = 1; cage B stays in reset with `ready_o[1]` = 0.
2. Glitch: in READY, pulse ModPrsL high for 2 cycles → `present_o` and `ready_o` unchanged, no reset pulse, count unchanged.
3. Removal during INIT_WAIT: ModPrsL high → ABSENT 6 edges later, `qsfp_reset_n_o` = 0, `ready_o` = 0; reinsertion gives a full sequence and count = 2.
4. `reset_req_i` in READY → `ready_o` drops the next cycle, 4-cycle reset pulse, ready again 12 cycles after entry; a `reset_req_i` during RESET_ASSERT causes no extension.
5. Saturation and priority: 300 `reset_req_i` → count holds at 255; `reset_req_i` coincident with debounced removal → ABSENT and count not incremented.
6. IntL low on both cages: cage in READY gets `int_o` = 1 after 2 edges; cage in INIT_WAIT gets `int_o` = 0; `gty_rst_n_i` asserted mid-sequence → all outputs zero asynchronously.
